sap_ram_ctrl: RTL

- Parametrised successor to the SAP 16x8 RAM.
- Single-clock memory array with a bus write/read port (tri-state output) and a handshaked programming loader that auto-increments its address.
- Runs a power-on clear sweep after reset.
- Sits on the SAP W-bus between MAR (address) and the bus/programming switches.

---
 rtl/sap_pkg.sv | 19 +
 rtl/sap_ram_loader.sv | 80 ++++++++
 rtl/sap_ram_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Shared types and default sizes for the SAP RAM controller slice.
//   ram_state_t : controller state (power-on clear, bus run, program loader)
//   SAP_DATA_W  : default word width
//   SAP_ADDR_W  : default address width (depth = 2**SAP_ADDR_W)
// ---------------------------------------------------------------------------
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  typedef enum logic [1:0] {
    RAM_INIT = 2'd0,
    RAM_RUN  = 2'd1,
    RAM_PROG = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap_ram_loader.sv
// ---------------------------------------------------------------------------
// sap_ram_loader
// Programming loader for the SAP RAM. Accepts words on a valid/ready
// handshake and presents them as a write strobe to the array owner, stepping
// its address after every accepted word and wrapping at the top of memory.
//
// Handshake: a word transfers on a rising clk_i edge where prog_valid_i and
// prog_ready_o are both 1. prog_ready_o is 1 for the whole time the
// controller is in programming mode; the producer may raise and drop
// prog_valid_i freely and the address only moves on a transfer.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   prog_mode_i       controller is in programming mode (drives ready)
//   start_i           controller enters programming mode this edge: addr -> 0
//   prog_valid_i      producer has a word
//   prog_data_i       producer word
//   prog_ready_o      loader accepts a word
//   prog_addr_o       address the next accepted word is written to
//   prog_done_o       one-cycle pulse after the word at the last address
//   wr_en_o           write strobe to the array
//   wr_addr_o         write address to the array
//   wr_data_o         write data to the array
// ---------------------------------------------------------------------------
module sap_ram_loader
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_mode_i,
  input  logic              start_i,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_ready_o,
  output logic [ADDR_W-1:0] prog_addr_o,
  output logic              prog_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  // Ready is decoded from the controller state so a reset drops it at once.
  assign prog_ready_o = prog_mode_i;
  assign wr_en_o      = prog_mode_i & prog_valid_i;
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = prog_data_i;
  assign prog_addr_o  = addr_q;
  assign prog_done_o  = done_q;

  always_comb begin
    addr_d = addr_q;
    done_d = 1'b0;
    if (start_i) begin
      addr_d = '0;
    end else if (wr_en_o) begin
      // Natural overflow wraps the last address back to 0.
      addr_d = addr_q + 1'b1;
      done_d = (addr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/sap_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sap_ram_ctrl
// SAP W-bus RAM: single-clock array with a bus write/read port (tri-state
// read data), a handshaked programming loader and an optional power-on clear
// sweep that zeroes every location after reset.
//
// Optional build macro: SAP_RAM_PARITY_EN adds a stored even-parity bit per
// word and a combinational read parity check on PARITY_ERR. Without it
// PARITY_ERR is tied low.
//
// Parameters: DATA_W (word width), ADDR_W (address width, depth 2**ADDR_W),
//             CLEAR_ON_RESET (1 = sweep zeroes after reset, 0 = keep contents)
//
// Ports:
//   CLOCK        system clock, all writes on the rising edge
//   _CLR         asynchronous active-low reset
//   RAM_IN       bus write data          ADDR_IN     bus address (from MAR)
//   EN_RAM_IN    bus write enable        EN_RAM_OUT  bus read/drive enable
//   RAM_OUT      read data, Z when not driving
//   _RAM_PROG    0 = programming mode, 1 = run mode
//   PROG_DATA    loader data             PROG_VALID  loader data valid
//   PROG_READY   loader accepts data     PROG_ADDR   next loader address
//   PROG_DONE    pulse after the loader writes the last location
//   BUSY         clear sweep in progress
//   PARITY_ERR   read parity mismatch
//
// Write ownership per edge: sweep in INIT, bus in RUN, loader in PROG, so
// at most one port writes on any edge.
// ---------------------------------------------------------------------------
module sap_ram_ctrl
  import sap_pkg::*;
#(
  parameter int DATA_W         = SAP_DATA_W,
  parameter int ADDR_W         = SAP_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLOCK,
  input  logic              _CLR,
  input  logic [DATA_W-1:0] RAM_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic              EN_RAM_IN,
  input  logic              EN_RAM_OUT,
  output logic [DATA_W-1:0] RAM_OUT,
  input  logic              _RAM_PROG,
  input  logic [DATA_W-1:0] PROG_DATA,
  input  logic              PROG_VALID,
  output logic              PROG_READY,
  output logic [ADDR_W-1:0] PROG_ADDR,
  output logic              PROG_DONE,
  output logic              BUSY,
  output logic              PARITY_ERR
);

  localparam int                DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam ram_state_t        RESET_STATE = CLEAR_ON_RESET ? RAM_INIT : RAM_RUN;

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ld_start;
  logic              ld_wr_en;
  logic [ADDR_W-1:0] ld_wr_addr;
  logic [DATA_W-1:0] ld_wr_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;

  // ---------------- controller FSM ----------------
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      RAM_INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = _RAM_PROG ? RAM_RUN : RAM_PROG;
        end
      end
      RAM_RUN: begin
        if (!_RAM_PROG) state_d = RAM_PROG;
      end
      RAM_PROG: begin
        if (_RAM_PROG) state_d = RAM_RUN;
      end
      default: state_d = RAM_RUN;
    endcase
  end

  always_ff @(posedge CLOCK or negedge _CLR) begin
    if (!_CLR) begin
      state_q   <= RESET_STATE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign BUSY     = (state_q == RAM_INIT);
  assign ld_start = (state_d == RAM_PROG) && (state_q != RAM_PROG);

  // ---------------- programming loader ----------------
  sap_ram_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk_i        (CLOCK),
    .rst_ni       (_CLR),
    .prog_mode_i  (state_q == RAM_PROG),
    .start_i      (ld_start),
    .prog_valid_i (PROG_VALID),
    .prog_data_i  (PROG_DATA),
    .prog_ready_o (PROG_READY),
    .prog_addr_o  (PROG_ADDR),
    .prog_done_o  (PROG_DONE),
    .wr_en_o      (ld_wr_en),
    .wr_addr_o    (ld_wr_addr),
    .wr_data_o    (ld_wr_data)
  );

  // ---------------- write arbitration ----------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ADDR_IN;
    wr_data = RAM_IN;
    case (state_q)
      RAM_INIT: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = '0;
      end
      RAM_RUN: begin
        wr_en = EN_RAM_IN;
      end
      RAM_PROG: begin
        wr_en   = ld_wr_en;
        wr_addr = ld_wr_addr;
        wr_data = ld_wr_data;
      end
      default: wr_en = 1'b0;
    endcase
    // No array writes while reset is held.
    if (!_CLR) wr_en = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // ---------------- read path ----------------
  // Reads see the array contents before the current edge (no write bypass).
  assign rd_en   = EN_RAM_OUT && (state_q != RAM_INIT);
  assign RAM_OUT = rd_en ? mem_q[ADDR_IN] : 'z;

`ifdef SAP_RAM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (wr_en) par_q[wr_addr] <= ^wr_data;
  end

  assign PARITY_ERR = rd_en && ((^mem_q[ADDR_IN]) != par_q[ADDR_IN]);
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule
